// File: rtl/cfu_simd_mac.sv
// Multi-cycle packed-SIMD multiply-accumulate CFU with an accumulator file and a back-pressurable response.
// Optional saturation and status word: define CFU_SIMD_MAC_SAT_EN.
//
// state  | meaning
// S_IDLE | waiting for a command, cmd_ready = 1
// S_EXEC | MAC in progress, down-counter runs MAC_LAT-1 .. 0
// S_RESP | response held until rsp_ready; a new command may be accepted alongside
module cfu_simd_mac #(
  parameter int LANES   = 4,
  parameter int NUM_ACC = 4,
  parameter int ACC_W   = 32,
  parameter int MAC_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_payload_response_ok,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int LW    = 32 / LANES;
  localparam int PW    = LW + 10;
  localparam int SW    = LW + 12;
  localparam int EW    = ((LW > 9) ? LW : 9) + 1;
  localparam int AIW   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int NSLOT = 1 << AIW;

  localparam logic [2:0] OP_SEL    = 3'd0;
  localparam logic [2:0] OP_SETOFF = 3'd1;
  localparam logic [2:0] OP_MAC    = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;
  localparam logic [2:0] OP_WRITE  = 3'd5;
`ifdef CFU_SIMD_MAC_SAT_EN
  localparam logic [2:0] OP_STAT   = 3'd6;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [6:0]         idx_q;
  logic [31:0]        a_q, b_q;
  logic [2:0]         cnt_q;
  logic signed [8:0]  off_q;
  logic [ACC_W-1:0]   acc_q [NSLOT];
  logic [31:0]        out_q;
  logic               ok_q;
`ifdef CFU_SIMD_MAC_SAT_EN
  logic               sat_q;
  logic               stat_clr;
`endif

  logic [2:0]         cmd_f3;
  logic [6:0]         cmd_f7;
  logic               accept;
  logic               cmd_idx_ok, exec_idx_ok;
  logic [AIW-1:0]     cmd_slot, exec_slot;

  logic [31:0]        imm_out;
  logic               imm_ok, off_we, acc_we;
  logic [ACC_W-1:0]   acc_wdata;
  logic signed [SW-1:0] mac_sum;
  logic [ACC_W-1:0]   mac_val;

  assign cmd_f3      = cmd_payload_function_id[2:0];
  assign cmd_f7      = cmd_payload_function_id[9:3];
  assign cmd_slot    = cmd_f7[AIW-1:0];
  assign exec_slot   = idx_q[AIW-1:0];
  assign cmd_idx_ok  = cmd_f7 < 7'(NUM_ACC);
  assign exec_idx_ok = idx_q < 7'(NUM_ACC);
  assign accept      = cmd_valid & cmd_ready;

  assign rsp_valid               = (state_q == S_RESP);
  assign rsp_payload_outputs_0   = out_q;
  assign rsp_payload_response_ok = ok_q;

  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready = 1'b1;
      S_RESP:  cmd_ready = rsp_ready;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Lane product truncated to LW+10 bits, lane sum kept at LW+12 bits.
  function automatic logic signed [SW-1:0] lane_mac_sum(input logic [31:0] a, input logic [31:0] b,
                                                        input logic signed [8:0] off);
    logic signed [LW-1:0]    a_l, b_l;
    logic signed [EW-1:0]    a_off;
    logic signed [EW+LW-1:0] prod_full;
    logic signed [PW-1:0]    prod;
    logic signed [SW-1:0]    sum;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      a_l       = a[i*LW +: LW];
      b_l       = b[i*LW +: LW];
      a_off     = EW'(a_l) + EW'(off);
      prod_full = (EW+LW)'(a_off) * (EW+LW)'(b_l);
      prod      = PW'(prod_full);
      sum       = sum + SW'(prod);
    end
    return sum;
  endfunction

  assign mac_sum = lane_mac_sum(a_q, b_q, off_q);

`ifdef CFU_SIMD_MAC_SAT_EN
  logic signed [ACC_W:0] mac_total;
  logic                  mac_ovf;
  always_comb begin
    mac_total = $signed({acc_q[exec_slot][ACC_W-1], acc_q[exec_slot]}) + (ACC_W+1)'(mac_sum);
    mac_ovf   = mac_total[ACC_W] ^ mac_total[ACC_W-1];
    mac_val   = mac_total[ACC_W-1:0];
    if (mac_ovf)
      mac_val = mac_total[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  always_comb mac_val = acc_q[exec_slot] + ACC_W'(mac_sum);
`endif

  // Single-cycle commands resolve at accept, straight from the bus.
  always_comb begin
    imm_out   = '0;
    imm_ok    = 1'b0;
    off_we    = 1'b0;
    acc_we    = 1'b0;
    acc_wdata = '0;
`ifdef CFU_SIMD_MAC_SAT_EN
    stat_clr  = 1'b0;
`endif
    case (cmd_f3)
      OP_SEL: begin
        imm_out = cmd_f7[0] ? cmd_payload_inputs_1 : cmd_payload_inputs_0;
        imm_ok  = 1'b1;
      end
      OP_SETOFF: begin
        imm_out = 32'(off_q);
        imm_ok  = 1'b1;
        off_we  = 1'b1;
      end
      OP_READ: if (cmd_idx_ok) begin
        imm_out = acc_q[cmd_slot];
        imm_ok  = 1'b1;
      end
      OP_CLEAR: if (cmd_idx_ok) begin
        imm_out = acc_q[cmd_slot];
        imm_ok  = 1'b1;
        acc_we  = 1'b1;
      end
      OP_WRITE: if (cmd_idx_ok) begin
        imm_out   = acc_q[cmd_slot];
        imm_ok    = 1'b1;
        acc_we    = 1'b1;
        acc_wdata = cmd_payload_inputs_0;
      end
`ifdef CFU_SIMD_MAC_SAT_EN
      OP_STAT: begin
        imm_out  = {sat_q, 31'b0};
        imm_ok   = 1'b1;
        stat_clr = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (cmd_f3 == OP_MAC) ? S_EXEC : S_RESP;
      S_EXEC: if (cnt_q == 3'd0) state_d = S_RESP;
      S_RESP: begin
        if (accept)         state_d = (cmd_f3 == OP_MAC) ? S_EXEC : S_RESP;
        else if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      idx_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      off_q <= '0;
      out_q <= '0;
      ok_q  <= 1'b0;
      for (int i = 0; i < NSLOT; i++) acc_q[i] <= '0;
`ifdef CFU_SIMD_MAC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q  <= cmd_f3;
        idx_q <= cmd_f7;
        a_q   <= cmd_payload_inputs_0;
        b_q   <= cmd_payload_inputs_1;
        if (cmd_f3 == OP_MAC) begin
          cnt_q <= 3'(MAC_LAT - 1);
        end else begin
          out_q <= imm_out;
          ok_q  <= imm_ok;
          if (off_we) off_q <= cmd_payload_inputs_0[8:0];
          if (acc_we) acc_q[cmd_slot] <= acc_wdata;
`ifdef CFU_SIMD_MAC_SAT_EN
          if (stat_clr) sat_q <= 1'b0;
`endif
        end
      end
      // The final EXEC cycle commits the accumulator and the response together.
      if (state_q == S_EXEC) begin
        if (cnt_q != 3'd0) begin
          cnt_q <= cnt_q - 3'd1;
        end else if (op_q == OP_MAC && exec_idx_ok) begin
          acc_q[exec_slot] <= mac_val;
          out_q            <= mac_val;
          ok_q             <= 1'b1;
`ifdef CFU_SIMD_MAC_SAT_EN
          if (mac_ovf) sat_q <= 1'b1;
`endif
        end else begin
          out_q <= '0;
          ok_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Self-checking bench for cfu_simd_mac: directed scenarios plus randomized commands
// checked against an opcode-level reference model.
module tb_cfu_simd_mac;
  localparam int LANES = 4, NUM_ACC = 4, MAC_LAT = 2, LW = 32 / LANES;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_ok;
  logic [9:0]  fid;
  logic [31:0] in0, in1, rsp_out;

  int n_pass = 0, n_total = 0;

  logic [31:0] m_acc [NUM_ACC];
  int          m_off;
  bit          m_sat;

  logic [31:0] got_out, exp_out;
  logic        got_ok, exp_ok;
  int          got_lat, exp_lat;

  always #5 clk = ~clk;

  cfu_simd_mac #(.LANES(LANES), .NUM_ACC(NUM_ACC), .ACC_W(32), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_response_ok(rsp_ok), .rsp_payload_outputs_0(rsp_out)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_mac(input logic [31:0] acc, input logic [31:0] a,
                                          input logic [31:0] b, input int off, output bit sat);
    longint s, t;
    logic [LW-1:0] la, lb;
    s = 0;
    sat = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      la = a[i*LW +: LW];
      lb = b[i*LW +: LW];
      s += (longint'($signed(la)) + longint'(off)) * longint'($signed(lb));
    end
    t = longint'($signed(acc)) + s;
`ifdef CFU_SIMD_MAC_SAT_EN
    if (t > 64'sd2147483647)  begin sat = 1'b1; return 32'h7FFF_FFFF; end
    if (t < -64'sd2147483648) begin sat = 1'b1; return 32'h8000_0000; end
`endif
    return t[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_ACC; i++) m_acc[i] = '0;
    m_off = 0;
    m_sat = 1'b0;
  endtask

  task automatic model_cmd(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                           input logic [31:0] b);
    bit legal;
    bit s;
    logic [1:0] slot;
    legal = (f7 < NUM_ACC);
    slot = f7[1:0];
    exp_out = '0;
    exp_ok = 1'b0;
    exp_lat = 1;
    case (f3)
      3'd0: begin exp_out = f7[0] ? b : a; exp_ok = 1'b1; end
      3'd1: begin exp_out = m_off; exp_ok = 1'b1; m_off = int'($signed(a[8:0])); end
      3'd2: begin
        exp_lat = 1 + MAC_LAT;
        if (legal) begin
          exp_out = ref_mac(m_acc[slot], a, b, m_off, s);
          m_acc[slot] = exp_out;
          exp_ok = 1'b1;
          if (s) m_sat = 1'b1;
        end
      end
      3'd3: if (legal) begin exp_out = m_acc[slot]; exp_ok = 1'b1; end
      3'd4: if (legal) begin exp_out = m_acc[slot]; exp_ok = 1'b1; m_acc[slot] = '0; end
      3'd5: if (legal) begin exp_out = m_acc[slot]; exp_ok = 1'b1; m_acc[slot] = a; end
`ifdef CFU_SIMD_MAC_SAT_EN
      3'd6: begin exp_out = m_sat ? 32'h8000_0000 : 32'h0; exp_ok = 1'b1; m_sat = 1'b0; end
`endif
      default: ;
    endcase
  endtask

  // Issues one command with rsp_ready high and collects the response; called at posedge+1.
  task automatic run(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                     input logic [31:0] b);
    int guard;
    model_cmd(f3, f7, a, b);
    fid = {f7, f3};
    in0 = a;
    in1 = b;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    got_lat = 1;
    while (!rsp_valid && got_lat < 60) begin @(posedge clk); #1; got_lat++; end
    got_out = rsp_out;
    got_ok = rsp_ok;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; fid = '0; in0 = '0; in1 = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    n_total++; if (rsp_out !== 32'h0) $display("FAIL reset_out: got %h want 0", rsp_out); else n_pass++;
    n_total++; if (rsp_ok !== 1'b0) $display("FAIL reset_ok: got %b want 0", rsp_ok); else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sel();
    for (int k = 1; k >= 0; k--) begin
      run(3'd0, 7'(k), 32'h1111_1111, 32'h2222_2222);
      n_total++; if (got_out !== (k ? 32'h2222_2222 : 32'h1111_1111)) $display("FAIL sel_out f7=%0d: got %h want %h", k, got_out, k ? 32'h2222_2222 : 32'h1111_1111); else n_pass++;
      n_total++; if (got_ok !== 1'b1) $display("FAIL sel_ok: got %b want 1", got_ok); else n_pass++;
      n_total++; if (got_lat !== 1) $display("FAIL sel_latency: got %0d want 1", got_lat); else n_pass++;
    end
  endtask

  task automatic test_mac_offset();
    run(3'd1, 7'd0, 32'h0000_0080, 32'h0);
    n_total++; if (got_out !== 32'h0) $display("FAIL setoff_old: got %h want 0", got_out); else n_pass++;
    run(3'd2, 7'd0, 32'h0102_0304, 32'h0101_0101);
    n_total++; if (got_out !== 32'h0000_020A) $display("FAIL mac_offset_out: got %h want 0000020a", got_out); else n_pass++;
    n_total++; if (got_lat !== 1 + MAC_LAT) $display("FAIL mac_latency: got %0d want %0d", got_lat, 1 + MAC_LAT); else n_pass++;
    run(3'd3, 7'd0, 32'h0, 32'h0);
    n_total++; if (got_out !== 32'h0000_020A) $display("FAIL read_after_mac: got %h want 0000020a", got_out); else n_pass++;
    run(3'd1, 7'd0, 32'h0000_01F0, 32'h0);
    n_total++; if (got_out !== 32'h0000_0080) $display("FAIL setoff_old2: got %h want 00000080", got_out); else n_pass++;
    run(3'd1, 7'd0, 32'h0, 32'h0);
    n_total++; if (got_out !== 32'hFFFF_FFF0) $display("FAIL setoff_neg: got %h want fffffff0", got_out); else n_pass++;
  endtask

  task automatic test_wrap();
    run(3'd5, 7'd1, 32'h7FFF_FF00, 32'h0);
    n_total++; if (got_out !== 32'h0) $display("FAIL write_old: got %h want 0", got_out); else n_pass++;
    run(3'd2, 7'd1, 32'h7F7F_7F7F, 32'h7F7F_7F7F);
`ifdef CFU_SIMD_MAC_SAT_EN
    n_total++; if (got_out !== 32'h7FFF_FFFF) $display("FAIL mac_sat: got %h want 7fffffff", got_out); else n_pass++;
    run(3'd6, 7'd0, 32'h0, 32'h0);
    n_total++; if (got_out !== 32'h8000_0000 || got_ok !== 1'b1) $display("FAIL status_set: got %h/%b want 80000000/1", got_out, got_ok); else n_pass++;
    run(3'd6, 7'd0, 32'h0, 32'h0);
    n_total++; if (got_out !== 32'h0) $display("FAIL status_clear: got %h want 0", got_out); else n_pass++;
`else
    n_total++; if (got_out !== 32'h8000_FB04) $display("FAIL mac_wrap: got %h want 8000fb04", got_out); else n_pass++;
    run(3'd6, 7'd0, 32'h0, 32'h0);
    n_total++; if (got_ok !== 1'b0 || got_out !== 32'h0) $display("FAIL op6_illegal: got %h/%b want 0/0", got_out, got_ok); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] nb;
    model_cmd(3'd3, 7'd0, 32'h0, 32'h0);
    fid = {7'd0, 3'd3}; in0 = '0; in1 = '0;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_total++; if (rsp_valid !== 1'b1) $display("FAIL hold_valid c=%0d: got %b want 1", c, rsp_valid); else n_pass++;
      n_total++; if (rsp_out !== exp_out) $display("FAIL hold_out c=%0d: got %h want %h", c, rsp_out, exp_out); else n_pass++;
      n_total++; if (cmd_ready !== 1'b0) $display("FAIL hold_cmd_ready c=%0d: got %b want 0", c, cmd_ready); else n_pass++;
      @(posedge clk); #1;
    end
    nb = $urandom;
    model_cmd(3'd0, 7'd1, 32'h0, nb);
    fid = {7'd1, 3'd0}; in1 = nb;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_total++; if (rsp_valid !== 1'b1 || rsp_out !== exp_out) $display("FAIL b2b_no_bubble: got %b/%h want 1/%h", rsp_valid, rsp_out, exp_out); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    run(3'd2, 7'(NUM_ACC), 32'h0102_0304, 32'h0505_0505);
    n_total++; if (got_ok !== 1'b0 || got_out !== 32'h0) $display("FAIL mac_bad_idx: got %h/%b want 0/0", got_out, got_ok); else n_pass++;
    n_total++; if (got_lat !== 1 + MAC_LAT) $display("FAIL mac_bad_idx_lat: got %0d want %0d", got_lat, 1 + MAC_LAT); else n_pass++;
    run(3'd7, 7'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    n_total++; if (got_ok !== 1'b0 || got_out !== 32'h0) $display("FAIL op7: got %h/%b want 0/0", got_out, got_ok); else n_pass++;
    run(3'd5, 7'd9, 32'hDEAD_BEEF, 32'h0);
    n_total++; if (got_ok !== 1'b0 || got_out !== 32'h0) $display("FAIL write_bad_idx: got %h/%b want 0/0", got_out, got_ok); else n_pass++;
    for (int i = 0; i < NUM_ACC; i++) begin
      run(3'd3, 7'(i), 32'h0, 32'h0);
      n_total++; if (got_out !== exp_out || got_ok !== 1'b1) $display("FAIL read_acc%0d: got %h/%b want %h/1", i, got_out, got_ok, exp_out); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [6:0] f7;
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom_range(0, 5));
      run(f3, f7, $urandom, $urandom);
      n_total++; if (got_out !== exp_out || got_ok !== exp_ok || got_lat !== exp_lat) $display("FAIL random n=%0d op=%0d idx=%0d: got %h/%b/%0d want %h/%b/%0d", n, f3, f7, got_out, got_ok, got_lat, exp_out, exp_ok, exp_lat); else n_pass++;
    end
  endtask

  task automatic test_reset_exec();
    bit seen;
    run(3'd5, 7'd2, 32'h5, 32'h0);
    fid = {7'd2, 3'd2}; in0 = 32'h0101_0101; in1 = 32'h0101_0101;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL abort_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    seen = rsp_valid;
    repeat (MAC_LAT + 3) begin @(posedge clk); #1; seen |= rsp_valid; end
    n_total++; if (seen !== 1'b0) $display("FAIL abort_rsp_valid: got %b want 0", seen); else n_pass++;
    run(3'd3, 7'd2, 32'h0, 32'h0);
    n_total++; if (got_out !== 32'h0 || got_ok !== 1'b1) $display("FAIL abort_read_acc2: got %h/%b want 0/1", got_out, got_ok); else n_pass++;
    run(3'd1, 7'd0, 32'h0, 32'h0);
    n_total++; if (got_out !== 32'h0) $display("FAIL abort_offset: got %h want 0", got_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sel();
    test_mac_offset();
    test_wrap();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_exec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
